// File: rtl/sdio_irq_pkg.sv
// sdio_irq_pkg
//   Shared definitions for the SDIO host interrupt controller:
//   coalescing FSM state encodings, register map offsets and the
//   register-bank byte count helper.
//
//   Register map layout (byte offsets from BASE_ADDR):
//     bank registers  : OFS_<bank> * NB + i    (i = 0 .. NB-1)
//     scalar registers: 2 * NB + OFS_<reg>
//     FORCE bank      : 2 * NB + OFS_FORCE + i (only with SDIO_IRQ_FORCE_EN)
package sdio_irq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COAL   = 2'd1,
    ASSERT = 2'd2
  } irq_state_e;

  // Bank indices; multiply by NB to get the first byte offset.
  localparam int OFS_STATUS   = 0;
  localparam int OFS_ENABLE   = 1;

  // Offsets relative to the end of the two banks (2 * NB).
  localparam int OFS_COAL_THR = 0;
  localparam int OFS_COAL_TMO = 1;
  localparam int OFS_CTRL     = 2;
  localparam int OFS_FORCE    = 3;

  // Number of register bytes needed to hold num_src bits.
  function automatic int calc_nb(input int num_src);
    return (num_src + 7) / 8;
  endfunction

endpackage

// File: rtl/sdio_irq_coal.sv
// sdio_irq_coal
//   Interrupt coalescing FSM with event counter and timeout timer.
//   IDLE -> COAL on a pending interrupt (or straight to ASSERT when the
//   threshold is 0); COAL -> ASSERT once enough enabled events have been
//   counted or the timeout expires; ASSERT holds irq until nothing is
//   pending.
//
//   Ports:
//     sys_clk  in   block clock
//     rst      in   asynchronous reset, active high
//     pend     in   at least one enabled status bit is set
//     new_evt  in   an enabled source rose this cycle
//     thr      in   COAL_W  event-count threshold (0 = no coalescing)
//     tmo      in   COAL_W  timeout in cycles (0 = timeout disabled)
//     irq      out  registered interrupt line
//     state    out  2      current FSM state
module sdio_irq_coal
  import sdio_irq_pkg::*;
#(
  parameter int COAL_W = 8
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              pend,
  input  logic              new_evt,
  input  logic [COAL_W-1:0] thr,
  input  logic [COAL_W-1:0] tmo,
  output logic              irq,
  output logic [1:0]        state
);

  irq_state_e        state_reg, state_next;
  logic [COAL_W-1:0] cnt_reg, cnt_next;
  logic [COAL_W-1:0] tmr_reg, tmr_next;
  logic              irq_reg;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      tmr_reg   <= '0;
      irq_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      tmr_reg   <= tmr_next;
      irq_reg   <= (state_next == ASSERT);
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    tmr_next   = tmr_reg;
    case (state_reg)
      IDLE: begin
        if (pend && (thr == '0)) begin
          state_next = ASSERT;
        end else if (pend) begin
          // The event that made pend rise counts as the first one.
          state_next = COAL;
          cnt_next   = COAL_W'(1);
          tmr_next   = '0;
        end
      end
      COAL: begin
        if (new_evt && (cnt_reg != '1)) cnt_next = cnt_reg + COAL_W'(1);
        if ((tmo != '0) && (tmr_reg != '1)) tmr_next = tmr_reg + COAL_W'(1);
        if (!pend) begin
          state_next = IDLE;
          cnt_next   = '0;
          tmr_next   = '0;
        end else if ((cnt_reg >= thr) ||
                     ((tmo != '0) && (tmr_reg >= (tmo - COAL_W'(1))))) begin
          // Compare registered count/timer so a THR write lands next cycle.
          state_next = ASSERT;
        end
      end
      ASSERT: begin
        if (!pend) begin
          state_next = IDLE;
          cnt_next   = '0;
          tmr_next   = '0;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        tmr_next   = '0;
      end
    endcase
  end

  assign irq   = irq_reg;
  assign state = state_reg;

endmodule

// File: rtl/sdio_irq_ctrl.sv
// sdio_irq_ctrl
//   Parametrised interrupt controller and register bank for the SDIO host.
//   Captures rising edges of NUM_SRC event inputs into sticky W1C status
//   bits, masks them with an enable bank and hands the result to the
//   coalescing FSM that drives the single host irq line.
//
//   Optional feature: define SDIO_IRQ_FORCE_EN to add the write-only FORCE
//   bank, which sets status bits from software exactly like a rising edge.
//
//   Ports:
//     sys_clk    in   block clock
//     rst        in   asynchronous reset, active high
//     reg_wr     in   byte write strobe
//     reg_addr   in   8  byte address
//     reg_wdata  in   8  write data
//     reg_rdata  out  8  read data, combinational from reg_addr
//     src_evt    in   NUM_SRC  event inputs (level or pulse)
//     irq        out  registered interrupt to host
//     irq_state  out  2  coalescing FSM state
module sdio_irq_ctrl
  import sdio_irq_pkg::*;
#(
  parameter int          NUM_SRC   = 16,
  parameter logic [7:0]  BASE_ADDR = 8'd32,
  parameter int          COAL_W    = 8
) (
  input  logic               sys_clk,
  input  logic               rst,
  input  logic               reg_wr,
  input  logic [7:0]         reg_addr,
  input  logic [7:0]         reg_wdata,
  output logic [7:0]         reg_rdata,
  input  logic [NUM_SRC-1:0] src_evt,
  output logic               irq,
  output logic [1:0]         irq_state
);

  localparam int NB    = calc_nb(NUM_SRC);
  localparam int NBITS = NB * 8;

  localparam logic [8:0] A_THR  = 9'(2 * NB + OFS_COAL_THR);
  localparam logic [8:0] A_TMO  = 9'(2 * NB + OFS_COAL_TMO);
  localparam logic [8:0] A_CTRL = 9'(2 * NB + OFS_CTRL);

  logic [NUM_SRC-1:0] src_d1_reg;
  logic [NUM_SRC-1:0] status_reg, status_next;
  logic [NUM_SRC-1:0] enable_reg, enable_next;
  logic [COAL_W-1:0]  thr_reg, tmo_reg;
  logic [NUM_SRC-1:0] rise, w1c, set_bits;
  logic [NB-1:0]      st_we, en_we;
  logic [NBITS-1:0]   status_pad, enable_pad;
  logic               pend, new_evt;

  // Offset from BASE_ADDR; bit 8 set means the address is below the bank.
  logic [8:0] ofs;
  logic       ofs_ok;
  assign ofs    = {1'b0, reg_addr} - {1'b0, BASE_ADDR};
  assign ofs_ok = ~ofs[8];

  assign rise = src_evt & ~src_d1_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_byte_we
      assign st_we[gi] = reg_wr && ofs_ok && (ofs == 9'(OFS_STATUS * NB + gi));
      assign en_we[gi] = reg_wr && ofs_ok && (ofs == 9'(OFS_ENABLE * NB + gi));
    end
    // Only bits below NUM_SRC exist, so writes to padding bits vanish here.
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_bit
      assign w1c[gi]         = st_we[gi / 8] & reg_wdata[gi % 8];
      assign enable_next[gi] = en_we[gi / 8] ? reg_wdata[gi % 8] : enable_reg[gi];
    end
  endgenerate

`ifdef SDIO_IRQ_FORCE_EN
  logic [NB-1:0]      fo_we;
  logic [NUM_SRC-1:0] force_set;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_force_we
      assign fo_we[gi] = reg_wr && ofs_ok && (ofs == 9'(2 * NB + OFS_FORCE + gi));
    end
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_force_bit
      assign force_set[gi] = fo_we[gi / 8] & reg_wdata[gi % 8];
    end
  endgenerate
  assign set_bits = rise | force_set;
`else
  assign set_bits = rise;
`endif

  // Set has priority over a simultaneous write-1-to-clear.
  assign status_next = set_bits | (status_reg & ~w1c);

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      src_d1_reg <= '0;
      status_reg <= '0;
      enable_reg <= '0;
      thr_reg    <= '0;
      tmo_reg    <= '0;
    end else begin
      src_d1_reg <= src_evt;
      status_reg <= status_next;
      enable_reg <= enable_next;
      if (reg_wr && ofs_ok && (ofs == A_THR)) thr_reg <= COAL_W'(reg_wdata);
      if (reg_wr && ofs_ok && (ofs == A_TMO)) tmo_reg <= COAL_W'(reg_wdata);
    end
  end

  assign pend    = |(status_reg & enable_reg);
  assign new_evt = |(rise & enable_reg);

  assign status_pad = NBITS'(status_reg);
  assign enable_pad = NBITS'(enable_reg);

  always_comb begin
    reg_rdata = 8'h00;
    if (ofs_ok) begin
      for (int i = 0; i < NB; i++) begin
        if (ofs == 9'(OFS_STATUS * NB + i)) reg_rdata = status_pad[i*8 +: 8];
        if (ofs == 9'(OFS_ENABLE * NB + i)) reg_rdata = enable_pad[i*8 +: 8];
      end
      if (ofs == A_THR)  reg_rdata = 8'(thr_reg);
      if (ofs == A_TMO)  reg_rdata = 8'(tmo_reg);
      if (ofs == A_CTRL) reg_rdata = {6'h0, irq_state};
    end
  end

  sdio_irq_coal #(
    .COAL_W (COAL_W)
  ) u_coal (
    .sys_clk (sys_clk),
    .rst     (rst),
    .pend    (pend),
    .new_evt (new_evt),
    .thr     (thr_reg),
    .tmo     (tmo_reg),
    .irq     (irq),
    .state   (irq_state)
  );

endmodule

// File: doc/sdio_irq_ctrl.md
Name: sdio_irq_ctrl

Overview:
- Parametrised interrupt controller and register bank for the SDIO host, in the sys_clk domain.
- Generalises the fixed 5-bit irq / 7-bit error status and enable registers to NUM_SRC sources with:
  - sticky write-1-to-clear status;
  - rising-edge capture;
  - interrupt coalescing by event count and timeout.
- Sits between the cmd/dat engines' event outputs and the CPU byte register bus; drives the single host irq line.

Parameters:
- NUM_SRC, 16, number of interrupt sources (1..64); NB = ceil(NUM_SRC/8) register bytes per bank.
- BASE_ADDR, 8'd32, first byte address of the bank.
- COAL_W, 8, width of coalescing threshold, event counter and timeout timer.

Ports:
- sys_clk  in  1  block clock.
- rst  in  1  asynchronous reset, active high.
- reg_wr  in  1  byte write strobe, one cycle per write.
- reg_addr  in  8  byte address.
- reg_wdata  in  8  write data.
- reg_rdata  out  8  read data, combinational from reg_addr.
- src_evt  in  NUM_SRC  event inputs, synchronous to sys_clk; level or pulse.
- irq  out  1  registered interrupt to host.
- irq_state  out  2  FSM state, for debug readback.

Behaviour:
- Address map, with offsets from BASE_ADDR:
  - STATUS[i] at i, for i < NB: R/W1C.
  - ENABLE[i] at NB+i: R/W.
  - COAL_THR at 2NB: R/W.
  - COAL_TMO at 2NB+1: R/W.
  - CTRL at 2NB+2: R/O, {6'h0, irq_state}.
  - All other addresses read 8'h00 and ignore writes.
- Bits at index >= NUM_SRC read 0 and ignore writes. COAL registers with COAL_W < 8 use the low bits, and the upper read bits are 0.
- Reset: status, enable, src_d1, COAL_THR, COAL_TMO, event counter and timer all go to 0; FSM goes to IDLE; irq=0, irq_state=0.
- Edge capture:
  - src_d1 <= src_evt every cycle; rise = src_evt & ~src_d1.
  - A source held high sets status exactly once.
- Status set/clear:
  - status[k] <= rise[k] | (status[k] & ~w1c[k]).
  - Set wins over a simultaneous write-1-to-clear.
  - Status sets regardless of enable.
- masked = status & enable; pend = |masked; new_evt = |(rise & enable).
- Latency: rise sampled at edge n is visible in status after edge n+1. With COAL_THR=0, irq is high after edge n+2.
- FSM, states IDLE=0, COAL=1, ASSERT=2:
  - IDLE:
    - If pend and COAL_THR==0, go to ASSERT.
    - Else if pend, go to COAL; cnt=1; tmr=0.
  - COAL:
    - cnt increments, saturating at 2^COAL_W-1, on each cycle with new_evt.
    - tmr increments every cycle when COAL_TMO != 0.
    - If !pend, go to IDLE (cnt and tmr cleared).
    - Else if cnt >= COAL_THR, or (COAL_TMO != 0 and tmr >= COAL_TMO-1), go to ASSERT.
    - COAL_TMO=0 disables the timeout.
  - ASSERT:
    - irq=1 while in this state; stay while pend.
    - If !pend, go to IDLE next cycle; irq drops the following cycle; cnt and tmr cleared.
- irq is a flop: irq <= (next_state==ASSERT).
- Writing ENABLE to 0 while in ASSERT makes pend=0, giving the IDLE transition above.
- Writing COAL_THR while in COAL takes effect in the comparison on the next cycle.
- Reset asserted mid-operation returns everything to reset values asynchronously; irq drops with no glitch-free requirement.

Optional Feature:
- Macro SDIO_IRQ_FORCE_EN.
- When defined: FORCE[i] at offset 2NB+3+i, write-only, reads 0. Writing 1 to a bit sets the matching status bit in the next cycle, exactly like a rise; this is for software and verification irq testing.
- When undefined: those addresses are unmapped, read 0, ignore writes, and no logic is generated.

Decomposition:
- Package sdio_irq_pkg holds:
  - FSM state encodings IDLE/COAL/ASSERT;
  - register offset localparams OFS_STATUS, OFS_ENABLE, OFS_COAL_THR, OFS_COAL_TMO, OFS_CTRL, OFS_FORCE;
  - an NB computation function.
- One sub-module, sdio_irq_coal: the FSM, event counter and timer. Inputs are pend, new_evt, thr and tmo; outputs are irq and state.
- The register bank and edge capture stay in the top module.

Test Plan:
- Reset, then read BASE..BASE+2NB+2 -> all 8'h00, irq=0.
- ENABLE0=8'h01, THR=0; pulse src_evt[0] for 1 cycle at edge n -> STATUS0 reads 8'h01 after n+1, irq=1 after n+2. Write STATUS0=8'h01 -> irq=0 two cycles later.
- Hold src_evt[3] high 10 cycles with enable=0 -> STATUS0=8'h08 set once, irq stays 0. Then write ENABLE0=8'h08 -> irq=1 two cycles later.
- THR=3, TMO=0, enable all; three single-cycle events on sources 1, 2, 5 spaced 4 cycles apart -> irq stays low until the cycle after the third event is counted; irq_state reads 1 then 2.
- THR=8'hFF, TMO=5; one enabled event -> irq asserts 5 cycles after COAL entry.
- src_evt[2] rising on the same cycle as a W1C of bit 2 -> status bit 2 remains 1. With SDIO_IRQ_FORCE_EN: write FORCE0=8'h40 -> STATUS0 bit 6 set next cycle.
